// File: rtl/zigbee_chip_spreader.sv
// zigbee_chip_spreader: byte FIFO feeding an 802.15.4 O-QPSK DSSS spreader, one chip per modulator ready edge
module zigbee_chip_spreader #(
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [7:0]       i_byte,
    output logic             o_byte_ready,
    input  logic             i_ready,
    output logic             o_empty,
    output logic             o_data,
    output logic             o_sym_done,
    output logic [LVL_W-1:0] o_fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;
    localparam logic [31:0] S0 = 32'b1101_1001_1100_0011_0101_0010_0010_1110;
    function automatic logic [31:0] sym_chips(input logic [3:0] s);
        logic [31:0] v;
        logic [4:0]  j;
        v = '0;
        for (int i = 0; i < 32; i++) begin
            j = 5'(i) - {s[2:0], 2'b00};
            v[i] = S0[5'd31 - j] ^ (s[3] & i[0]);
        end
        return v;
    endfunction
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [LVL_W-1:0] r_level;
    logic             r_ready_q, r_nib, r_data, r_empty, r_sym_done;
    logic [0:0]       r_state;
    logic [31:0]      r_chips;
    logic [4:0]       r_idx;
    logic [3:0]       r_hi;
    logic             w_edge, w_send, w_last, w_push, w_pop, w_nonempty;
    logic [7:0]       w_head;
    logic [31:0]      w_lo, w_hi;
    assign o_byte_ready = r_level != LVL_W'(FIFO_DEPTH);
    assign o_fifo_level = r_level;
    assign o_empty      = r_empty;
    assign o_data       = r_data;
    assign o_sym_done   = r_sym_done;
    assign w_edge       = i_ready & ~r_ready_q;
    assign w_send       = (r_state == SEND) & w_edge;
    assign w_last       = r_idx == 5'd31;
    assign w_nonempty   = r_level != '0;
    assign w_push       = i_valid & o_byte_ready;
    // pop either to start a frame from IDLE or to chain the next byte after its high nibble
    assign w_pop        = w_nonempty & ((r_state == IDLE) ? w_edge : (w_send & w_last & r_nib));
    assign w_head       = r_mem[r_rd];
    assign w_lo         = sym_chips(w_head[3:0]);
    assign w_hi         = sym_chips(r_hi);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_level    <= '0;
            r_ready_q  <= 1'b0;
            r_state    <= IDLE;
            r_chips    <= '0;
            r_idx      <= '0;
            r_nib      <= 1'b0;
            r_hi       <= '0;
            r_data     <= 1'b0;
            r_empty    <= 1'b1;
            r_sym_done <= 1'b0;
        end else begin
            r_ready_q  <= i_ready;
            r_sym_done <= w_send & w_last;
            r_level    <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
            if (w_push) begin
                r_mem[r_wr] <= i_byte;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd    <= r_rd + AW'(1);
                r_chips <= w_lo;
                r_data  <= w_lo[0];
                r_hi    <= w_head[7:4];
                r_idx   <= '0;
                r_nib   <= 1'b0;
                r_state <= SEND;
                r_empty <= 1'b0;
            end else if (w_send & ~w_last) begin
                r_idx  <= r_idx + 5'd1;
                r_data <= r_chips[r_idx + 5'd1];
            end else if (w_send & ~r_nib) begin
                r_chips <= w_hi;
                r_data  <= w_hi[0];
                r_idx   <= '0;
                r_nib   <= 1'b1;
            end else if (w_send) begin
                r_empty <= 1'b1;
                r_state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_zigbee_chip_spreader.sv
// tb_zigbee_chip_spreader: randomized scoreboard bench; expected chips are queued per pushed byte and popped per consumed chip
module tb_zigbee_chip_spreader;
    logic       clk = 1'b0, reset = 1'b1, i_valid = 1'b0, i_ready = 1'b0;
    logic [7:0] i_byte = '0;
    logic       o_byte_ready, o_empty, o_data, o_sym_done;
    logic [2:0] o_fifo_level;
    bit         rom [16][32];
    bit         exp_q [$];
    int         checks = 0, errors = 0, n_cons = 0;
    bit         prev_rdy = 0, sd_next = 0, watch = 0;

    zigbee_chip_spreader dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_byte(i_byte),
        .o_byte_ready(o_byte_ready), .i_ready(i_ready), .o_empty(o_empty),
        .o_data(o_data), .o_sym_done(o_sym_done), .o_fifo_level(o_fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic consume(input int n);
        repeat (n) begin
            i_ready = 1'b1;
            tick();
            i_ready = 1'b0;
            tick();
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        for (int h = 0; h < 2; h++)
            for (int i = 0; i < 32; i++)
                exp_q.push_back(rom[h == 0 ? b[3:0] : b[7:4]][i]);
    endtask

    task automatic push(input logic [7:0] b);
        i_valid = 1'b1;
        i_byte  = b;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (o_byte_ready) begin
                model_push(b);
                tick();
                i_valid = 1'b0;
                return;
            end
            tick();
        end
        check("push_timeout", 1, 0);
        i_valid = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_empty", o_empty, 1);
        check("rst_data", o_data, 0);
        check("rst_sym_done", o_sym_done, 0);
        check("rst_byte_ready", o_byte_ready, 1);
        check("rst_level", o_fifo_level, 0);
    endtask

    // chip table built from the symbol-0 string by rotation and odd-chip inversion
    initial begin
        string s0 = "11011001110000110101001000101110";
        bit q [$];
        for (int i = 0; i < 32; i++) q.push_back(s0[i] == "1");
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 32; i++) begin
                rom[k][i]     = q[i];
                rom[k + 8][i] = q[i] ^ (i % 2 == 1);
            end
            repeat (4) q.push_front(q.pop_back());
        end
    end

    initial forever begin
        @(negedge clk);
        check("sym_done", o_sym_done, sd_next);
        if (watch) check("stream_valid", o_empty, 0);
        if (reset) begin
            exp_q.delete();
            n_cons   = 0;
            sd_next  = 0;
            prev_rdy = 0;
        end else begin
            sd_next = 0;
            if (i_ready && !prev_rdy && !o_empty) begin
                if (exp_q.size() == 0) check("chip_unexpected", 1, 0);
                else check("chip", o_data, exp_q.pop_front());
                n_cons++;
                sd_next = (n_cons % 32 == 0);
            end
            prev_rdy = i_ready;
        end
    end

    initial begin
        logic [7:0] b;
        int c0;
        repeat (3) tick();
        check_reset_vals();
        reset = 1'b0;
        tick();
        push(8'h00);
        i_ready = 1'b1;
        tick();
        check("latency_empty", o_empty, 0);
        check("latency_c0", o_data, rom[0][0]);
        i_ready = 1'b0;
        tick();
        consume(64);
        check("t1_end_empty", o_empty, 1);
        check("t1_queue", exp_q.size(), 0);

        push(8'h81);
        consume(1);
        check("t2_c0", o_data, rom[1][0]);
        consume(64);
        check("t2_end_empty", o_empty, 1);

        for (int i = 0; i < 4; i++) push(8'($urandom));
        check("t3_full_ready", o_byte_ready, 0);
        check("t3_full_level", o_fifo_level, 4);
        consume(1);
        check("t3_pop_level", o_fifo_level, 3);
        consume(32);
        check("t3_level32", o_fifo_level, 3);
        check("t3_ready32", o_byte_ready, 1);
        consume(32 + 3 * 64);
        check("t3_end_empty", o_empty, 1);
        check("t3_end_level", o_fifo_level, 0);

        push(8'h10);
        consume(1);
        watch = 1;
        fork
            consume(127);
            begin
                repeat (20) tick();
                push(8'h32);
            end
        join
        watch = 0;
        consume(1);
        check("t4_end_empty", o_empty, 1);

        b = 8'($urandom);
        push(b);
        consume(1);
        c0 = n_cons;
        i_ready = 1'b1;
        repeat (10) tick();
        i_ready = 1'b0;
        tick();
        check("t5_hold_one", n_cons - c0, 1);
        consume(63);
        check("t5_drain_empty", o_empty, 1);
        c0 = n_cons;
        repeat (3) begin
            i_ready = 1'b1;
            tick();
            i_ready = 1'b0;
            tick();
        end
        check("t5_idle_cons", n_cons - c0, 0);
        check("t5_idle_empty", o_empty, 1);
        check("t5_idle_level", o_fifo_level, 0);
        b = 8'($urandom);
        push(b);
        consume(1);
        check("t5_next_c0", o_data, rom[b[3:0]][0]);
        consume(64);

        push(8'h05);
        consume(1);
        consume(17);
        check("t6_mid_empty", o_empty, 0);
        reset = 1'b1;
        tick();
        check_reset_vals();
        reset = 1'b0;
        tick();
        push(8'h00);
        consume(1);
        check("t6_restart_c0", o_data, rom[0][0]);
        consume(64);
        check("t6_end_empty", o_empty, 1);
        check("final_queue", exp_q.size(), 0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
